// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
//
// Optional feature macro: MEM_ARB_RR_EN (round-robin on contention instead of fixed data priority)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request and word address
//   if_gnt/if_rvalid/if_rdata   fetch accept, response valid, response data
//   d_req/d_we/d_addr/d_wdata   load/store request, write enable, byte address, store data
//   d_gnt/d_rvalid/d_rdata      load/store accept, load response valid, load data
//   mem_addr/mem_we/mem_wdata   memory request side
//   mem_rdata                   memory read data, one cycle after the address
//   hold                        fetch requested but not granted this cycle
//   block_inst                  registered hold; decoder substitutes a bubble
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-3:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              hold,
    output logic              block_inst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2,
        WR_D  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   d_win;

`ifdef MEM_ARB_RR_EN
    // rr_if=1 means the fetch side wins the next contended cycle.
    logic rr_if;

    assign d_win = d_req & ~(if_req & rr_if);

    // Only contended cycles move the pointer; the winner always yields next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_if <= 1'b0;
        end else if (if_req && d_req) begin
            rr_if <= ~rr_if;
        end
    end
`else
    assign d_win = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            block_inst <= 1'b0;
        end else begin
            state      <= state_next;
            block_inst <= hold;
        end
    end

    always_comb begin
        d_gnt      = d_win;
        if_gnt     = if_req & ~d_win;
        hold       = if_req & ~if_gnt;
        mem_addr   = {if_addr, 2'b00};
        mem_we     = 1'b0;
        mem_wdata  = '0;
        state_next = IDLE;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        d_rvalid   = 1'b0;
        d_rdata    = '0;

        if (d_gnt) begin
            mem_addr   = d_addr;
            // Write strobe is suppressed during reset so memory is never corrupted.
            mem_we     = d_we & rst_n;
            mem_wdata  = d_we ? d_wdata : '0;
            state_next = d_we ? WR_D : RD_D;
        end else if (if_gnt) begin
            state_next = RD_IF;
        end

        // The state names last cycle's transaction, so the response simply forwards memory data.
        case (state)
            RD_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            RD_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [29:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;
    logic        hold, block_inst;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .hold(hold), .block_inst(block_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [29:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] rd;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_hold;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_rd = '0;
    vec_t        tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic [29:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd, input logic [31:0] rd,
                                input logic eig, input logic edg, input logic [31:0] ea,
                                input logic ew, input logic [31:0] ewd, input logic eh);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd; v.rd = rd;
        v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_addr = ea;
        v.e_we = ew; v.e_wdata = ewd; v.e_hold = eh;
        return v;
    endfunction

    task automatic check_resp(input string tag);
        logic        ev_if, ev_d;
        logic [31:0] ed_if, ed_d;
        resp_t       r;
        ev_if = 1'b0; ev_d = 1'b0; ed_if = '0; ed_d = '0;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.is_d) begin ev_d = 1'b1; ed_d = r.data; end
            else begin ev_if = 1'b1; ed_if = r.data; end
        end
        check({tag, " if_rvalid"}, 64'(if_rvalid), 64'(ev_if));
        check({tag, " if_rdata"}, 64'(if_rdata), 64'(ed_if));
        check({tag, " d_rvalid"}, 64'(d_rvalid), 64'(ev_d));
        check({tag, " d_rdata"}, 64'(d_rdata), 64'(ed_d));
    endtask

    // One bus cycle: drive at posedge+1, sample at posedge+2.
    task automatic apply_vec(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        mem_rdata = prev_rd;
        if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        #1;
        check_resp(tag);
        check({tag, " block_inst"}, 64'(block_inst), 64'(prev_hold));
        check({tag, " if_gnt"}, 64'(if_gnt), 64'(v.e_if_gnt));
        check({tag, " d_gnt"}, 64'(d_gnt), 64'(v.e_d_gnt));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(v.e_addr));
        check({tag, " mem_we"}, 64'(mem_we), 64'(v.e_we));
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(v.e_wdata));
        check({tag, " hold"}, 64'(hold), 64'(v.e_hold));
        if (v.e_if_gnt) sb.push_back('{is_d: 1'b0, data: v.rd});
        if (v.e_d_gnt && !v.d_we) sb.push_back('{is_d: 1'b1, data: v.rd});
        prev_hold = v.e_hold;
        prev_rd = v.rd;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        sb.delete();
        prev_hold = 1'b0;
        #1;
        check("rst if_rvalid", 64'(if_rvalid), 64'd0);
        check("rst d_rvalid", 64'(d_rvalid), 64'd0);
        check("rst block_inst", 64'(block_inst), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic dw;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = 32'h5A5A5A5A;

        tbl[0] = mk(0, 30'h3, 0, 0, 32'h0, 32'h0, 32'h11111111, 0, 0, 32'hC, 0, 32'h0, 0);
        tbl[1] = mk(1, 30'h4, 0, 0, 32'h0, 32'h0, 32'h00500093, 1, 0, 32'h10, 0, 32'h0, 0);
        tbl[2] = mk(1, 30'h8, 1, 0, 32'h100, 32'h12345678, 32'hCAFEF00D, 0, 1, 32'h100, 0, 32'h0, 1);
        tbl[3] = mk(0, 30'h5, 1, 1, 32'h200, 32'hDEADBEEF, 32'h0, 0, 1, 32'h200, 1, 32'hDEADBEEF, 0);
        tbl[4] = mk(0, 30'h6, 1, 0, 32'h203, 32'h0, 32'hA5A5A5A5, 0, 1, 32'h203, 0, 32'h0, 0);
        tbl[5] = mk(1, 30'h3FFFFFFF, 0, 0, 32'h0, 32'h0, 32'h0BADC0DE, 1, 0, 32'hFFFFFFFC, 0, 32'h0, 0);
        tbl[6] = mk(1, 30'h7, 0, 0, 32'h0, 32'h0, 32'h77777777, 1, 0, 32'h1C, 0, 32'h0, 0);
        tbl[7] = mk(0, 30'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);

        #2;
        check("init if_rvalid", 64'(if_rvalid), 64'd0);
        check("init d_rvalid", 64'(d_rvalid), 64'd0);
        check("init if_rdata", 64'(if_rdata), 64'd0);
        check("init d_rdata", 64'(d_rdata), 64'd0);
        check("init block_inst", 64'(block_inst), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Sustained contention from a fresh reset.
        do_reset();
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            dw = (k % 2 == 0);
`else
            dw = 1'b1;
`endif
            v = mk(1, 30'h10 + 30'(k), 1, 0, 32'h300 + 32'(4 * k), 32'hFFFF0000, 32'h1000 + 32'(k),
                   !dw, dw, dw ? 32'h300 + 32'(4 * k) : 32'(32'h40 + 32'(4 * k)), 0, 32'h0, dw);
            apply_vec(v, $sformatf("cont%0d", k));
        end
        apply_vec(tbl[7], "cont_drain");

        // Fetch granted, then reset before its response edge.
        apply_vec(tbl[1], "midrd_fetch");
        #1;
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h12121212;
        #1;
        check("midrd d_gnt", 64'(d_gnt), 64'd1);
        check("midrd mem_we", 64'(mem_we), 64'd0);
        check("midrd mem_addr", 64'(mem_addr), 64'h44);
        sb.delete();
        prev_hold = 1'b0;
        @(posedge clk);
        #1;
        mem_rdata = 32'h00500093;
        #1;
        check("midrd if_rvalid", 64'(if_rvalid), 64'd0);
        check("midrd if_rdata", 64'(if_rdata), 64'd0);
        check("midrd d_rvalid", 64'(d_rvalid), 64'd0);
        check("midrd block_inst", 64'(block_inst), 64'd0);
        d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("post if_rvalid", 64'(if_rvalid), 64'd0);
        check("post block_inst", 64'(block_inst), 64'd0);
        prev_rd = '0;
        apply_vec(tbl[6], "post_fetch");
        apply_vec(tbl[7], "post_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
